// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Request/completion handshake between an operation issuer and the ALU
// sequencer.
//   op_valid : issuer has an operation request present
//   op_code  : 3-bit operation code (NOP/ADD/SUB/XOR/MUL/LDA, 110/111 illegal)
//   op_ready : sequencer can accept a request this cycle
//   done     : one-cycle completion pulse
//   illegal  : one-cycle pulse with done for illegal op codes
// Modports: master = issuer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ready;
    logic       done;
    logic       illegal;

    modport master (
        output op_valid,
        output op_code,
        input  op_ready,
        input  done,
        input  illegal
    );

    modport slave (
        input  op_valid,
        input  op_code,
        output op_ready,
        output done,
        output illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Control sequencer for a small ALU datapath. Accepts one operation at a time
// and steps it through LOAD, EXEC (EXEC_CYCLES hold cycles so the multiplier
// can settle) and WB, then pulses done.
//
// Parameters:
//   EXEC_CYCLES  : execute-phase hold cycles, legal range 1..15
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous, active-low reset
//   op_if        : request/completion handshake (slave modport)
//   a_enable     : load enable for the ALU A register (LOAD only)
//   acc_enable   : load enable for both accumulators (WB only)
//   addsub       : datapath select, 1 = subtract
//   xor_ctrl     : datapath select, 1 = logic/multiplier path
//   mul_out_ctrl : datapath select, 1 = multiplier output
//   op_count     : (only with ALU_SEQ_OPCOUNT_EN) count of completed
//                  non-NOP legal operations, wraps at 16 bits
// Optional feature macro: ALU_SEQ_OPCOUNT_EN
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_sequencer_if.slave   op_if,
    output logic             a_enable,
    output logic             acc_enable,
    output logic             addsub,
    output logic             xor_ctrl,
    output logic             mul_out_ctrl
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;

    // EXEC runs while the counter walks from EXEC_CYCLES-1 down to 0.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WB,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [3:0] r_cnt;
    logic       w_accept;
    logic       w_in_op;

    assign w_accept = op_if.op_valid && op_if.op_ready;

    // State, captured opcode and exec down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= op_if.op_code;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_if.op_code)
                        OP_ADD, OP_SUB, OP_XOR, OP_MUL, OP_LDA: w_next = S_LOAD;
                        default:                                w_next = S_DONE;
                    endcase
                end
            end
            S_LOAD: begin
                // LDA only needs the A-register load, no execute/writeback.
                w_next = (r_op == OP_LDA) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_WB;
                end
            end
            S_WB:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the captured opcode only; op_ready is
    // additionally gated by rst so it drops the instant reset asserts.
    always_comb begin
        op_if.op_ready = (r_state == S_IDLE) && rst;
        a_enable       = (r_state == S_LOAD);
        acc_enable     = (r_state == S_WB);
        op_if.done     = (r_state == S_DONE);
        op_if.illegal  = (r_state == S_DONE) && (r_op[2:1] == 2'b11);
        addsub         = 1'b0;
        xor_ctrl       = 1'b0;
        mul_out_ctrl   = 1'b0;
        w_in_op        = (r_state == S_LOAD) || (r_state == S_EXEC) ||
                         (r_state == S_WB);
        if (w_in_op) begin
            case (r_op)
                OP_SUB: addsub = 1'b1;
                OP_XOR: xor_ctrl = 1'b1;
                OP_MUL: begin
                    xor_ctrl     = 1'b1;
                    mul_out_ctrl = 1'b1;
                end
                default: begin
                    addsub       = 1'b0;
                    xor_ctrl     = 1'b0;
                    mul_out_ctrl = 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_count <= 16'd0;
        end else if (r_state == S_DONE && r_op[2:1] != 2'b11 && r_op != OP_NOP) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning execute-phase hold cycles (legal range 1..15), so the multiplier output can settle.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port op_valid  input  1  an operation request is present.
REQ-005 SHALL have port op_code  input  3  operation code: 000 NOP, 001 ADD, 010 SUB, 011 XOR, 100 MUL, 101 LDA, 110/111 illegal.
REQ-006 SHALL have port op_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port a_enable  output  1  load enable for the ALU A register.
REQ-008 SHALL have port acc_enable  output  1  load enable for both accumulators.
REQ-009 SHALL have ports addsub, xor_ctrl and mul_out_ctrl, each output 1, carrying the ALU datapath selects.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse, coincident with done, for illegal opcodes.

Function
REQ-012 SHALL implement the states IDLE, LOAD, EXEC, WB and DONE.
REQ-013 SHALL drive op_ready=1 only in IDLE while rst is high; a request SHALL be accepted on a clock edge where op_valid=1 and op_ready=1, and op_code SHALL be captured internally at that edge.
REQ-014 SHALL make op_code changes after acceptance have no effect until the next acceptance.
REQ-015 SHALL transition on accepting ADD/SUB/XOR/MUL as IDLE->LOAD (1 cycle)->EXEC (EXEC_CYCLES cycles, down-counter)->WB (1 cycle)->DONE (1 cycle)->IDLE.
REQ-016 SHALL transition on accepting LDA as IDLE->LOAD->DONE->IDLE.
REQ-017 SHALL transition on accepting NOP or an illegal code as IDLE->DONE->IDLE, with no enables asserted.
REQ-018 SHALL assert a_enable=1 only in LOAD, and acc_enable=1 only in WB.
REQ-019 SHALL drive the select values ADD: addsub=0,xor_ctrl=0,mul_out_ctrl=0; SUB: 1,0,0; XOR: 0,1,0; MUL: 0,1,1.
REQ-020 SHALL hold the selects constant from LOAD through WB inclusive, and drive them 0 in IDLE and DONE.
REQ-021 SHALL assert done=1 for exactly the DONE cycle, and illegal=1 in that cycle only for codes 110/111.
REQ-022 SHALL give accept-to-done latency of EXEC_CYCLES+3 cycles for arithmetic ops, 2 cycles for LDA, and 1 cycle for NOP/illegal.
REQ-023 SHALL permit a new acceptance at the earliest in the cycle after DONE, with no back-to-back overlap.
REQ-024 SHALL drive all outputs from registers or decoded state only, with no combinational path from op_valid or op_code to any output.

Reset
REQ-025 SHALL, when rst is low, force state to IDLE, the exec counter to 0, and a_enable, acc_enable, addsub, xor_ctrl, mul_out_ctrl, done, illegal and op_ready to 0 immediately, regardless of the clock.
REQ-026 SHALL, on reset asserted mid-operation, abandon the operation with no done pulse; op_ready SHALL become 1 once rst is high.

Configuration
REQ-027 SHALL, when ALU_SEQ_OPCOUNT_EN is defined, add output op_count[15:0], reset to 0, incremented on each done pulse where illegal=0 and the op is not NOP, wrapping from 16'hFFFF to 16'h0000.
REQ-028 SHALL, when ALU_SEQ_OPCOUNT_EN is undefined, omit the op_count port and counter, leaving all other behaviour identical.

Verification
REQ-029 SHALL cover: EXEC_CYCLES=1, ADD accepted at cycle 0 -> a_enable high at cycle 1, acc_enable high at cycle 3, done high at cycle 4, op_ready=1 at cycle 5.
REQ-030 SHALL cover: EXEC_CYCLES=4, MUL -> xor_ctrl=1 and mul_out_ctrl=1 held for 6 cycles (LOAD..WB), done at cycle 7.
REQ-031 SHALL cover: op_code 111 -> done=1 and illegal=1 at cycle 1, with a_enable and acc_enable never asserted.
REQ-032 SHALL cover: rst driven low during EXEC of SUB -> all outputs 0 within the same cycle, no done pulse, next ADD completes normally.
REQ-033 SHALL cover: op_valid held high continuously with SUB, and op_code toggled to XOR mid-operation -> addsub stays 1 and xor_ctrl stays 0, with the next op accepted the cycle after done.
REQ-034 SHALL cover: with ALU_SEQ_OPCOUNT_EN defined and op_count preset to 16'hFFFF by 65535 ops, one more ADD -> op_count=16'h0000; a NOP leaves op_count unchanged.
